// File: rtl/id_stage.sv
// Decode stage: field extract, 15-entry register file, control decode, ID/EXE register.
// Define REGFILE_BYPASS_EN to make same-cycle write-back visible on the register reads.
module id_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        freeze_i,
  input  logic        flush_i,
  input  logic        hazard_i,
  input  logic [31:0] PC_in_i,
  input  logic [31:0] Instruction_in_i,
  input  logic [3:0]  SR_i,
  input  logic        WB_WB_EN_i,
  input  logic [3:0]  WB_Dest_i,
  input  logic [31:0] WB_Value_i,
  output logic [31:0] PC_o,
  output logic [31:0] Val_Rn_o,
  output logic [31:0] Val_Rm_o,
  output logic [11:0] Shift_operand_o,
  output logic [23:0] Signed_imm_24_o,
  output logic [3:0]  Dest_o,
  output logic [3:0]  EXE_CMD_o,
  output logic        MEM_R_EN_o,
  output logic        MEM_W_EN_o,
  output logic        WB_EN_o,
  output logic        B_o,
  output logic        S_o,
  output logic        imm_o,
  output logic [3:0]  Src1_o,
  output logic [3:0]  Src2_o,
  output logic        Two_src_o
);

  logic [3:0]  cond, opcode, rn, rd, rm;
  logic [1:0]  mode;
  logic        i_bit, s_bit;

  assign cond   = Instruction_in_i[31:28];
  assign mode   = Instruction_in_i[27:26];
  assign i_bit  = Instruction_in_i[25];
  assign opcode = Instruction_in_i[24:21];
  assign s_bit  = Instruction_in_i[20];
  assign rn     = Instruction_in_i[19:16];
  assign rd     = Instruction_in_i[15:12];
  // STR reads its store data through the Rm port
  assign rm     = (mode == 2'b01 && !s_bit) ? rd : Instruction_in_i[3:0];

  assign Src1_o    = rn;
  assign Src2_o    = rm;
  assign Two_src_o = (mode == 2'b00 && !i_bit) || (mode == 2'b01 && !s_bit);

  // register file R0-R14; index 15 is hardwired to zero
  logic [14:0][31:0] rf_q;
  logic              wb_we;

  assign wb_we = WB_WB_EN_i && (WB_Dest_i != 4'd15);

  always_ff @(posedge clk_i) begin
    if (rst_i)      rf_q <= '0;
    else if (wb_we) rf_q[WB_Dest_i] <= WB_Value_i;
  end

  logic [31:0] val_rn, val_rm;

  always_comb begin
    val_rn = (rn == 4'd15) ? 32'd0 : rf_q[rn];
    val_rm = (rm == 4'd15) ? 32'd0 : rf_q[rm];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && WB_Dest_i == rn) val_rn = WB_Value_i;
    if (wb_we && WB_Dest_i == rm) val_rm = WB_Value_i;
`endif
  end

  // condition evaluation on {N,Z,C,V}
  logic n_f, z_f, c_f, v_f, cond_ok;
  assign {n_f, z_f, c_f, v_f} = SR_i;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // control word {EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S}
  logic [3:0] exe_d;
  logic       mr_d, mw_d, wb_d, b_d, s_d;

  always_comb begin
    exe_d = 4'd0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    wb_d  = 1'b0;
    b_d   = 1'b0;
    s_d   = 1'b0;
    case (mode)
      2'b00: begin
        wb_d = 1'b1;
        s_d  = s_bit;
        case (opcode)
          4'b1101: exe_d = 4'b0001;
          4'b1111: exe_d = 4'b1001;
          4'b0100: exe_d = 4'b0010;
          4'b0101: exe_d = 4'b0011;
          4'b0010: exe_d = 4'b0100;
          4'b0110: exe_d = 4'b0101;
          4'b0000: exe_d = 4'b0110;
          4'b1100: exe_d = 4'b0111;
          4'b0001: exe_d = 4'b1000;
          4'b1010: begin exe_d = 4'b0100; wb_d = 1'b0; end
          4'b1000: begin exe_d = 4'b0110; wb_d = 1'b0; end
          default: begin wb_d = 1'b0; s_d = 1'b0; end
        endcase
      end
      2'b01: begin
        exe_d = 4'b0010;
        mr_d  = s_bit;
        wb_d  = s_bit;
        mw_d  = !s_bit;
      end
      2'b10: b_d = 1'b1;
      default: ;
    endcase
  end

  logic bubble;
  assign bubble = flush_i || hazard_i || !cond_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      PC_o            <= '0;
      Val_Rn_o        <= '0;
      Val_Rm_o        <= '0;
      Shift_operand_o <= '0;
      Signed_imm_24_o <= '0;
      Dest_o          <= '0;
      imm_o           <= 1'b0;
      EXE_CMD_o       <= '0;
      MEM_R_EN_o      <= 1'b0;
      MEM_W_EN_o      <= 1'b0;
      WB_EN_o         <= 1'b0;
      B_o             <= 1'b0;
      S_o             <= 1'b0;
    end else if (flush_i || !freeze_i) begin
      // flush outranks freeze; data fields always follow the instruction
      PC_o            <= PC_in_i;
      Val_Rn_o        <= val_rn;
      Val_Rm_o        <= val_rm;
      Shift_operand_o <= Instruction_in_i[11:0];
      Signed_imm_24_o <= Instruction_in_i[23:0];
      Dest_o          <= rd;
      imm_o           <= i_bit;
      EXE_CMD_o       <= bubble ? 4'd0 : exe_d;
      MEM_R_EN_o      <= !bubble && mr_d;
      MEM_W_EN_o      <= !bubble && mw_d;
      WB_EN_o         <= !bubble && wb_d;
      B_o             <= !bubble && b_d;
      S_o             <= !bubble && s_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard;
  logic [31:0] pc_in, instr;
  logic [3:0]  sr;
  logic        wb_we;
  logic [3:0]  wb_dest;
  logic [31:0] wb_val;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shop;
  logic [23:0] imm24;
  logic [3:0]  dest, exe, src1, src2;
  logic        mr, mw, wb_en, b, s, imm, two_src;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush), .hazard_i(hazard),
    .PC_in_i(pc_in), .Instruction_in_i(instr), .SR_i(sr),
    .WB_WB_EN_i(wb_we), .WB_Dest_i(wb_dest), .WB_Value_i(wb_val),
    .PC_o(pc), .Val_Rn_o(val_rn), .Val_Rm_o(val_rm), .Shift_operand_o(shop),
    .Signed_imm_24_o(imm24), .Dest_o(dest), .EXE_CMD_o(exe),
    .MEM_R_EN_o(mr), .MEM_W_EN_o(mw), .WB_EN_o(wb_en), .B_o(b), .S_o(s), .imm_o(imm),
    .Src1_o(src1), .Src2_o(src2), .Two_src_o(two_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] d, input logic [31:0] v);
    wb_we = 1'b1; wb_dest = d; wb_val = v;
    step();
    wb_we = 1'b0;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
    pc_in = 32'h40; instr = 32'hE3A01005; sr = 4'b0000;
    // write to R3 during reset must be overridden
    wb_we = 1'b1; wb_dest = 4'd3; wb_val = 32'h1234;
    #1;
    step(); step();
    wb_we = 1'b0;
    chk("rst_exe",  {28'd0, exe}, 32'd0);
    chk("rst_pc",   pc, 32'd0);
    chk("rst_dest", {28'd0, dest}, 32'd0);
    chk("rst_wb",   {31'd0, wb_en}, 32'd0);
    chk("rst_shop", {20'd0, shop}, 32'd0);
    rst = 1'b0;

    wb_write(4'd0, 32'd3);
    wb_write(4'd1, 32'd5);
    wb_write(4'd4, 32'h1111);

    // MOV R1,#5
    pc_in = 32'h100; instr = 32'hE3A01005;
    step();
    chk("mov_exe",  {28'd0, exe}, 32'h1);
    chk("mov_imm",  {31'd0, imm}, 32'd1);
    chk("mov_dest", {28'd0, dest}, 32'd1);
    chk("mov_wb",   {31'd0, wb_en}, 32'd1);
    chk("mov_shop", {20'd0, shop}, 32'h005);
    chk("mov_pc",   pc, 32'h100);

    // ADD R2,R0,R1
    instr = 32'hE0802001; #1;
    chk("add_two_src", {31'd0, two_src}, 32'd1);
    chk("add_src1", {28'd0, src1}, 32'd0);
    chk("add_src2", {28'd0, src2}, 32'd1);
    step();
    chk("add_rn",  val_rn, 32'd3);
    chk("add_rm",  val_rm, 32'd5);
    chk("add_exe", {28'd0, exe}, 32'h2);

    // MOVEQ: condition fails then passes
    instr = 32'h03A01005; sr = 4'b0000;
    step();
    chk("moveq_f_wb",  {31'd0, wb_en}, 32'd0);
    chk("moveq_f_exe", {28'd0, exe}, 32'd0);
    chk("moveq_f_dest", {28'd0, dest}, 32'd1);
    sr = 4'b0100;
    step();
    chk("moveq_t_wb",  {31'd0, wb_en}, 32'd1);
    chk("moveq_t_exe", {28'd0, exe}, 32'h1);
    sr = 4'b0000;

    // CMP R0,R1
    instr = 32'hE1500001;
    step();
    chk("cmp_exe", {28'd0, exe}, 32'h4);
    chk("cmp_wb",  {31'd0, wb_en}, 32'd0);
    chk("cmp_s",   {31'd0, s}, 32'd1);

    // STR R3,[R2,#4]: Rm port reads Rd (R3 was cleared by reset)
    instr = 32'hE5823004; #1;
    chk("str_two_src", {31'd0, two_src}, 32'd1);
    chk("str_src2", {28'd0, src2}, 32'd3);
    step();
    chk("str_mw",  {31'd0, mw}, 32'd1);
    chk("str_exe", {28'd0, exe}, 32'h2);
    chk("str_wb",  {31'd0, wb_en}, 32'd0);
    chk("str_rm",  val_rm, 32'd0);

    // LDR R3,[R2,#4]
    instr = 32'hE5923004; #1;
    chk("ldr_two_src", {31'd0, two_src}, 32'd0);
    step();
    chk("ldr_mr", {31'd0, mr}, 32'd1);
    chk("ldr_wb", {31'd0, wb_en}, 32'd1);
    chk("ldr_mw", {31'd0, mw}, 32'd0);

    // branch with and without flush
    instr = 32'hEA000002; flush = 1'b1;
    step();
    chk("bfl_b",   {31'd0, b}, 32'd0);
    chk("bfl_imm", {8'd0, imm24}, 32'h2);
    flush = 1'b0;
    step();
    chk("br_b",   {31'd0, b}, 32'd1);
    chk("br_imm", {8'd0, imm24}, 32'h2);

    // hazard: control bubble, data fields still load
    instr = 32'hE3A01005; pc_in = 32'h180; hazard = 1'b1;
    step();
    chk("hz_exe",  {28'd0, exe}, 32'd0);
    chk("hz_wb",   {31'd0, wb_en}, 32'd0);
    chk("hz_dest", {28'd0, dest}, 32'd1);
    chk("hz_pc",   pc, 32'h180);
    hazard = 1'b0;

    // same-cycle write-back of R4 read as Rn
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hDEAD;
`else
    exp_byp = 32'h1111;
`endif
    instr = 32'hE0845000;
    wb_write(4'd4, 32'hDEAD);
    chk("byp_rn", val_rn, exp_byp);
    step();
    chk("byp_after", val_rn, 32'hDEAD);

    // R15 is never written and reads zero
    instr = 32'hE08F5000;
    wb_write(4'd15, 32'hFFFF);
    chk("r15_rn", val_rn, 32'd0);

    // freeze holds outputs while write-back continues
    instr = 32'hE3A01005; pc_in = 32'h200;
    step();
    freeze = 1'b1; instr = 32'hE1500001; pc_in = 32'h300;
    wb_write(4'd0, 32'h77);
    instr = 32'hE0802001; pc_in = 32'h304;
    step();
    chk("frz_exe",  {28'd0, exe}, 32'h1);
    chk("frz_pc",   pc, 32'h200);
    chk("frz_dest", {28'd0, dest}, 32'd1);
    chk("frz_s",    {31'd0, s}, 32'd0);
    freeze = 1'b0;
    step();
    chk("frz_wr_rn", val_rn, 32'h77);
    chk("frz_rel_pc", pc, 32'h304);

    // reset in the middle of a freeze
    freeze = 1'b1; rst = 1'b1;
    step();
    chk("rfz_exe",  {28'd0, exe}, 32'd0);
    chk("rfz_pc",   pc, 32'd0);
    chk("rfz_rn",   val_rn, 32'd0);
    chk("rfz_dest", {28'd0, dest}, 32'd0);
    rst = 1'b0; freeze = 1'b0;
    step();
    chk("rfz_rf_r0", val_rn, 32'd0);
    chk("rfz_rf_r1", val_rm, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
